// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a single-port RAM (optional fairness: ARB_FAIR_EN)
module mem_port_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter int FAIR_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_mem_q, gnt_mem_d;   // 1 = current access belongs to MEM, 0 = IF
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  lat_q, lat_d;
  logic        cancel_q, cancel_d;     // sticky: in-flight fetch was flushed
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        if_pend;
  logic        grant_mem;
  logic        grant_if;
  logic        fair_force;

  // Word-offset address bits are never used; FAIR_MAX is only live in the fair build.
  logic        unused_bits;
  assign unused_bits = ^{if_addr[1:0], mem_addr[1:0], 3'(FAIR_MAX)};

  // A fetch only competes for the RAM when it is not being redirected this cycle.
  assign if_pend = if_req & ~flush;

`ifdef ARB_FAIR_EN
  logic [2:0] fair_q, fair_d;

  // Force an IF grant once MEM has won FAIR_MAX times in a row against a waiting fetch.
  assign fair_force = mem_req & if_pend & (fair_q == 3'(FAIR_MAX));

  // Count MEM grants made while a fetch was waiting; any IF grant restarts the count.
  always_comb begin
    fair_d = fair_q;
    if (grant_if) begin
      fair_d = 3'd0;
    end else if (grant_mem && if_req && (fair_q < 3'(FAIR_MAX))) begin
      fair_d = fair_q + 3'd1;
    end
  end

  // Fairness counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_q <= 3'd0;
    end else begin
      fair_q <= fair_d;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // State and datapath registers; reset discards any in-flight RAM result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 30'd0;
      wdata_q     <= 32'd0;
      lat_q       <= 4'd0;
      cancel_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      gnt_mem_q   <= gnt_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      cancel_q    <= cancel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state, grant decision, RAM strobes and ack pulses.
  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    cancel_d    = cancel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant_mem   = 1'b0;
    grant_if    = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (fair_force) begin
          grant_if = 1'b1;
        end else if (mem_req) begin
          grant_mem = 1'b1;
        end else if (if_pend) begin
          grant_if = 1'b1;
        end

        if (grant_mem) begin
          state_d   = S_ISSUE;
          gnt_mem_d = 1'b1;
          we_d      = mem_we;
          addr_d    = mem_addr[31:2];
          wdata_d   = mem_wdata;
        end else if (grant_if) begin
          state_d   = S_ISSUE;
          gnt_mem_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr[31:2];
          wdata_d   = 32'd0;
        end
      end

      S_ISSUE: begin
        ram_en  = 1'b1;
        ram_we  = we_q;
        lat_d   = 4'(MEM_LAT - 1);
        state_d = S_WAIT;
        if (!gnt_mem_q && flush) begin
          cancel_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (!gnt_mem_q && flush) begin
          cancel_d = 1'b1;
        end
        if (lat_q == 4'd0) begin
          state_d = S_DONE;
          if (gnt_mem_q) begin
            if (!we_q) begin
              mem_rdata_d = ram_rdata;
            end
          end else if (!cancel_q && !flush) begin
            if_rdata_d = ram_rdata;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (gnt_mem_q) begin
          mem_ack = 1'b1;
        end else begin
          if_ack = ~cancel_q & ~flush;
          if (flush) begin
            cancel_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter (MEM_LAT=2)
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_chk;
  int n_pass;

  logic [31:0] ram [0:255];
  logic [31:0] rd_s1;
  logic [31:0] rd_s2;
  int          we_cnt;

  mem_port_arbiter #(.MEM_LAT(2), .FAIR_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: two-stage read pipeline gives data two cycles after ram_en.
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram[ram_addr[7:0]] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    rd_s1 <= ram_en ? ram[ram_addr[7:0]] : 32'h0;
    rd_s2 <= rd_s1;
  end
  assign ram_rdata = rd_s2;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    string seq_obs;
    string seq_exp;
    int    base_we;
    n_chk = 0;
    n_pass = 0;
    we_cnt = 0;
    rd_s1 = 32'h0;
    rd_s2 = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h04] = 32'h8C010004;  // byte 0x10
    ram[8'h08] = 32'hAAAA5555;  // byte 0x20
    ram[8'h09] = 32'h0BADF00D;  // byte 0x24
    ram[8'h10] = 32'hDEADBEEF;  // byte 0x40
    ram[8'h11] = 32'h00000013;  // byte 0x44

    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    tick; tick;
    #3 rst = 1'b1;
    tick;

    // Reset state
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
    chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_addr", {2'd0, ram_addr}, 32'd0);

    // T1: single fetch of 0x10
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("t1_stall_if_c0", {31'd0, stall_if}, 32'd1);
    chk("t1_ram_en_c0", {31'd0, ram_en}, 32'd0);
    tick;
    chk("t1_ram_en_c1", {31'd0, ram_en}, 32'd1);
    chk("t1_ram_we_c1", {31'd0, ram_we}, 32'd0);
    chk("t1_ram_addr_c1", {2'd0, ram_addr}, 32'h4);
    tick;
    chk("t1_ram_en_c2", {31'd0, ram_en}, 32'd0);
    tick;
    chk("t1_if_ack_c3", {31'd0, if_ack}, 32'd0);
    tick;
    chk("t1_if_ack_c4", {31'd0, if_ack}, 32'd1);
    chk("t1_stall_if_c4", {31'd0, stall_if}, 32'd0);
    chk("t1_if_rdata", if_rdata, 32'h8C010004);
    if_req = 1'b0;
    tick;
    chk("t1_if_ack_c5", {31'd0, if_ack}, 32'd0);

    // T2: simultaneous fetch 0x44 and load 0x40; MEM first
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    tick;
    chk("t2_ram_addr_c1", {2'd0, ram_addr}, 32'h10);
    tick; tick; tick;
    chk("t2_mem_ack_c4", {31'd0, mem_ack}, 32'd1);
    chk("t2_mem_rdata", mem_rdata, 32'hDEADBEEF);
    chk("t2_stall_if_c4", {31'd0, stall_if}, 32'd1);
    chk("t2_stall_mem_c4", {31'd0, stall_mem}, 32'd0);
    mem_req = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      tick;
      chk($sformatf("t2_stall_if_c%0d", c), {31'd0, stall_if}, 32'd1);
      chk($sformatf("t2_if_ack_c%0d", c), {31'd0, if_ack}, 32'd0);
    end
    tick;
    chk("t2_if_ack_c9", {31'd0, if_ack}, 32'd1);
    chk("t2_if_rdata", if_rdata, 32'h00000013);
    if_req = 1'b0;
    tick;

    // T3: store then load at 0x80
    base_we = we_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
    tick;
    chk("t3_ram_we_c1", {31'd0, ram_we}, 32'd1);
    chk("t3_ram_addr_c1", {2'd0, ram_addr}, 32'h20);
    chk("t3_ram_wdata_c1", ram_wdata, 32'h12345678);
    tick; tick; tick;
    chk("t3_st_ack_c4", {31'd0, mem_ack}, 32'd1);
    chk("t3_st_rdata_kept", mem_rdata, 32'hDEADBEEF);
    mem_we = 1'b0;
    tick; tick; tick; tick; tick;
    chk("t3_ld_ack_c9", {31'd0, mem_ack}, 32'd1);
    chk("t3_ld_rdata", mem_rdata, 32'h12345678);
    chk("t3_we_pulses", we_cnt - base_we, 32'd1);
    mem_req = 1'b0;
    tick;

    // T4: fetch 0x20 flushed in WAIT, then fetch 0x24
    if_req = 1'b1; if_addr = 32'h20;
    tick; tick;
    flush = 1'b1; if_req = 1'b0;
    tick;
    flush = 1'b0;
    chk("t4_if_ack_c3", {31'd0, if_ack}, 32'd0);
    tick;
    chk("t4_if_ack_c4", {31'd0, if_ack}, 32'd0);
    tick;
    chk("t4_if_rdata_kept", if_rdata, 32'h00000013);
    if_req = 1'b1; if_addr = 32'h24;
    tick; tick; tick; tick;
    chk("t4_if_ack_next", {31'd0, if_ack}, 32'd1);
    chk("t4_if_rdata_next", if_rdata, 32'h0BADF00D);
    if_req = 1'b0;
    tick;

    // Flush in IDLE with only a fetch pending: no grant that cycle
    if_req = 1'b1; if_addr = 32'h10; flush = 1'b1;
    tick;
    chk("fi_no_grant", {31'd0, ram_en}, 32'd0);
    flush = 1'b0;
    tick;
    chk("fi_grant_later", {31'd0, ram_en}, 32'd1);
    tick; tick; tick;
    chk("fi_if_ack", {31'd0, if_ack}, 32'd1);
    chk("fi_if_rdata", if_rdata, 32'h8C010004);
    if_req = 1'b0;
    tick;

    // T5: async reset during WAIT
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    tick; tick;
    #1 rst = 1'b0;
    #1;
    chk("t5_ram_en", {31'd0, ram_en}, 32'd0);
    chk("t5_mem_ack", {31'd0, mem_ack}, 32'd0);
    chk("t5_mem_rdata", mem_rdata, 32'd0);
    chk("t5_if_rdata", if_rdata, 32'd0);
    chk("t5_ram_addr", {2'd0, ram_addr}, 32'd0);
    mem_req = 1'b0;
    tick;
    #3 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk($sformatf("t5_no_stale_ack_%0d", c), {30'd0, mem_ack, if_ack}, 32'd0);
    end
    if_req = 1'b1; if_addr = 32'h24;
    tick;
    chk("t5_idle_grant", {31'd0, ram_en}, 32'd1);
    tick; tick; tick;
    chk("t5_if_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    tick;

`ifdef ARB_FAIR_EN
    // T6: both held high; IF forced after four MEM grants
    seq_obs = "";
    seq_exp = "MMMMIM";
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    for (int c = 0; c < 60 && seq_obs.len() < 6; c++) begin
      tick;
      if (mem_ack) seq_obs = {seq_obs, "M"};
      if (if_ack) seq_obs = {seq_obs, "I"};
    end
    chk("t6_ack_count", seq_obs.len(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_ack_%0d", k),
          (k < seq_obs.len()) ? {24'd0, seq_obs[k]} : 32'd0, {24'd0, seq_exp[k]});
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick;
`else
    seq_obs = "";
    seq_exp = "";
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
